// File: rtl/dec_entry_pkg.sv
// Shared constants, debouncer state encoding and counter-width helper for dec_entry.
package dec_entry_pkg;

    localparam int unsigned MAX_DIGITS = 3;
    localparam int unsigned MAX_VALUE  = 999;
    localparam int unsigned MAX_DIGIT  = 9;

    localparam int unsigned LEDR_W = $clog2(MAX_VALUE + 1);
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned SW_W   = 4;
    localparam int unsigned KEY_W  = 3;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_e;

    // Width of a counter that must reach cycles-1 (at least one bit).
    function automatic int unsigned db_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned DB_CNT_W = db_cnt_w(DEFAULT_DEBOUNCE_CYCLES);

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer for an active-low, already synchronized key.
// Ports: clk, rst_n (async active-low), key_sync (synced key, 0 = pressed),
//        press (registered one-cycle strobe on qualified press).
module key_debounce
    import dec_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_sync,
    output logic press
);

    localparam int unsigned CW = db_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    db_state_e     state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          press_nxt;

    // State, stability counter and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            press   <= press_nxt;
        end
    end

    // Next state; counter restarts on every state change or level flip.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = '0;
        case (state_q)
            DB_IDLE: begin
                if (!key_sync) state_nxt = DB_PRESS_WAIT;
            end
            DB_PRESS_WAIT: begin
                if (key_sync)           state_nxt = DB_IDLE;
                else if (cnt_q == LAST) state_nxt = DB_HELD;
                else                    cnt_nxt   = cnt_q + CW'(1);
            end
            DB_HELD: begin
                if (key_sync) state_nxt = DB_RELEASE_WAIT;
            end
            DB_RELEASE_WAIT: begin
                if (!key_sync)          state_nxt = DB_HELD;
                else if (cnt_q == LAST) state_nxt = DB_IDLE;
                else                    cnt_nxt   = cnt_q + CW'(1);
            end
            default: state_nxt = DB_IDLE;
        endcase
    end

    // Strobe only on the PRESS_WAIT -> HELD transition.
    always_comb begin
        press_nxt = 1'b0;
        if (state_q == DB_PRESS_WAIT && !key_sync && cnt_q == LAST) press_nxt = 1'b1;
    end

endmodule

// File: rtl/dec_entry.sv
// Three-digit decimal entry: debounced enter/backspace/clear keys build a
// binary value from switch digits.
// Ports: CLOCK_50, RESET_N (async active-low), SW[3:0] digit, KEY[2:0]
//        active-low buttons (0 enter, 1 backspace, 2 clear); LEDR value,
//        CNT digit count, ERR sticky error, VALID one-cycle update pulse.
module dec_entry
    import dec_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [SW_W-1:0]   SW,
    input  logic [KEY_W-1:0]  KEY,
    output logic [LEDR_W-1:0] LEDR,
    output logic [CNT_W-1:0]  CNT,
    output logic              ERR,
    output logic              VALID
);

    logic [KEY_W-1:0] key_s1, key_s2;
    logic [SW_W-1:0]  sw_s1, sw_s2;
    logic [KEY_W-1:0] press;
    logic             sw_bad;
    logic             full;

    // Two-flop synchronizers; reset to the idle level.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    for (genvar g = 0; g < KEY_W; g++) begin : g_db
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .key_sync(key_s2[g]),
            .press   (press[g])
        );
    end

    assign sw_bad = (sw_s2 > SW_W'(MAX_DIGIT));
    assign full   = (CNT == CNT_W'(MAX_DIGITS));

    // Entry datapath: clear > backspace > enter.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            LEDR  <= '0;
            CNT   <= '0;
            ERR   <= 1'b0;
            VALID <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (press[2]) begin
                LEDR  <= '0;
                CNT   <= '0;
                ERR   <= 1'b0;
                VALID <= 1'b1;
            end else if (press[1]) begin
                if (CNT != '0) begin
                    LEDR  <= LEDR / LEDR_W'(10);
                    CNT   <= CNT - CNT_W'(1);
                    VALID <= 1'b1;
                end
            end else if (press[0]) begin
                if (sw_bad || full) begin
                    ERR <= 1'b1;
                end else begin
                    // LEDR <= 99 here, so the result fits in LEDR_W bits.
                    LEDR  <= LEDR * LEDR_W'(10) + LEDR_W'(sw_s2);
                    CNT   <= CNT + CNT_W'(1);
                    VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dec_entry.md
DEC_ENTRY -- requirements
Module: dec_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable synchronized samples that qualifies a key press or release (10 ms at 50 MHz).
REQ-002 Ports:
- CLOCK_50 input 1: sole clock; all state updates on its rising edge.
- RESET_N input 1: asynchronous, active-low reset.
- SW input 4: decimal digit to enter, binary 0..9.
- KEY input 3: active-low pushbuttons.
  - KEY[0] enters a digit.
  - KEY[1] is backspace.
  - KEY[2] clears the entry.
- LEDR output 10: accumulated binary value, 0..999.
- CNT output 2: number of digits entered, 0..3.
- ERR output 1: sticky error flag.
- VALID output 1: one-cycle pulse marking a value update.

Function
REQ-003 KEY[2:0] and SW[3:0] SHALL each pass through a 2-flop synchronizer before any use.
REQ-004 Each key SHALL have its own debouncer with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-005 Debouncer transitions SHALL be:
- IDLE->PRESS_WAIT when the synced key reads 0.
- PRESS_WAIT->HELD after DEBOUNCE_CYCLES consecutive 0 samples; any 1 sample returns to IDLE.
- HELD->RELEASE_WAIT when the synced key reads 1.
- RELEASE_WAIT->IDLE after DEBOUNCE_CYCLES consecutive 1 samples; any 0 sample returns to HELD.
REQ-006 A debouncer SHALL emit a one-cycle press strobe on the PRESS_WAIT->HELD transition, and only there, so one physical press yields exactly one strobe.
REQ-007 The press strobe SHALL update LEDR, CNT, ERR and VALID on the next clock edge (1-cycle latency).
REQ-008 Enter strobe with synced SW<=9 and CNT<3 SHALL set LEDR = LEDR*10 + SW, computed at 10-bit width without truncation (max 999), and CNT = CNT+1.
REQ-009 Enter strobe with synced SW>9 SHALL leave LEDR and CNT unchanged and set ERR.
REQ-010 Enter strobe with CNT==3 SHALL leave LEDR and CNT unchanged and set ERR.
REQ-011 Backspace strobe with CNT>0 SHALL set LEDR = LEDR/10 (integer division) and CNT = CNT-1; with CNT==0 it SHALL have no effect.
REQ-012 Clear strobe SHALL set LEDR=0, CNT=0 and ERR=0.
REQ-013 Strobes arriving in the same cycle SHALL be resolved by priority clear > backspace > enter; lower-priority strobes in that cycle are discarded.
REQ-014 VALID SHALL pulse for exactly one cycle after any strobe that changes LEDR or CNT, and after a clear.
REQ-015 VALID SHALL stay 0 after a rejected enter and after a no-op backspace.
REQ-016 ERR SHALL stay 1 until a clear strobe or reset; backspace does not clear it.
REQ-017 Holding a key indefinitely SHALL produce no repeat strobes.
REQ-018 SW changes while no enter strobe is present SHALL have no effect.

Reset
REQ-019 RESET_N low SHALL immediately force LEDR=0, CNT=0, ERR=0, VALID=0, all debouncers to IDLE, debounce counters to 0 and synchronizers to the idle level (KEY flops 1, SW flops 0).
REQ-020 Reset asserted while a debouncer is in PRESS_WAIT SHALL discard that press; no strobe is emitted after release of reset.
REQ-021 A key already held low when reset releases SHALL be debounced as a fresh press and produce one strobe.

Structure
REQ-022 A shared package dec_entry_pkg SHALL hold MAX_DIGITS=3, MAX_VALUE=999, the debouncer state encoding and the counter width derived from DEBOUNCE_CYCLES.
REQ-023 The debouncer SHALL be a sub-module key_debounce (inputs: clock, reset, synced key; output: press strobe), instantiated three times.
REQ-024 The entry datapath SHALL stay in dec_entry.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Enter digits 1, 2, 3 in sequence -> LEDR 1, then 12, then 123; CNT 1, 2, 3; one VALID pulse per press; ERR=0.
REQ-026 From 123, enter 4 -> LEDR=123, CNT=3, ERR=1, no VALID; then backspace -> LEDR=12, CNT=2, ERR still 1.
REQ-027 With SW=12, press enter -> LEDR and CNT unchanged, ERR=1; then clear -> LEDR=0, CNT=0, ERR=0, VALID pulses once.
REQ-028 KEY[0] low for 3 cycles then high (glitch) -> no strobe, no change; KEY[0] held low for 1000 cycles -> exactly one update.
REQ-029 KEY[1] and KEY[2] press strobes in the same cycle with LEDR=45 -> LEDR=0, CNT=0 (clear wins).
REQ-030 RESET_N pulsed low mid-PRESS_WAIT with LEDR=99 -> all outputs 0 asynchronously; no strobe after reset release while the key is high.
